core_store_buffer: RTL and testbench
====================================

# core_store_buffer

Parametrised store buffer with store-to-load forwarding between the execute stage and the data memory port of the core. It replaces the fixed one- and two-cycle delayed store/load address compare with a DEPTH-entry FIFO. The FIFO absorbs stores, drains them to memory under a ready handshake, and forwards the youngest matching bytes to loads. Loads that only partly overlap a buffered store raise a stall until the conflicting entries have drained.

## Interface
- DEPTH, 4: number of buffered stores; power of two, ≥2
- ADDR_W, 32: byte address width
- DATA_W, 32: data width; multiple of 8; BE_W = DATA_W/8 lanes

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- st_valid  in  1  store request from EX
- st_addr  in  ADDR_W  store byte address
- st_data  in  DATA_W  store data, already lane-aligned
- st_be  in  BE_W  store byte enables
- st_ready  out  1  buffer accepts a store this cycle
- ld_valid  in  1  load lookup request from EX
- ld_addr  in  ADDR_W  load byte address
- ld_be  in  BE_W  requested load lanes
- ld_hit  out  1  all requested lanes are supplied by the buffer
- ld_data  out  DATA_W  forwarded data; lanes not covered are 0
- ld_stall  out  1  partial overlap; the load must retry
- mem_we  out  1  head entry is valid for commit
- mem_addr  out  ADDR_W  head address
- mem_data  out  DATA_W  head data
- mem_be  out  BE_W  head byte enables
- mem_ready  in  1  memory accepts the head this cycle
- empty  out  1  no entries held
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage is a circular FIFO with head pointer `hp`, tail pointer `tp` (both $clog2(DEPTH) bits, wrapping), and `count`.
- Push: `st_valid & st_ready`. Writes {addr, data, be} at `tp`, then `tp++`.
- Pop: `mem_we & mem_ready`. Then `hp++`.
- `st_ready = (count != DEPTH)`. This is purely registered state: a store is not accepted when full, even if a pop happens in the same cycle.
- Simultaneous push and pop at 0 < count < DEPTH leaves `count` unchanged.
- When empty, a push does not pass straight through to memory. `mem_we` rises the following cycle.
- `mem_we = !empty`. `mem_*` present the entry at `hp`. They hold stable until a pop.
- An `st_be` of 0 is still accepted and committed. Memory treats it as a no-op write.

Forwarding (combinational, while `ld_valid`):
- Match key is the word index, `addr[ADDR_W-1:$clog2(BE_W)]`.
- Candidates are all valid entries plus the store being pushed in this cycle, which counts as youngest.
- For each lane i with `ld_be[i]`, take byte i from the youngest candidate whose key matches and whose `be[i]` is set.
- `covered` = OR of matching entries' `be`, masked by `ld_be`.
- `ld_hit = ld_valid & (covered == ld_be) & (ld_be != 0)`.
- `ld_stall = ld_valid & (covered != 0) & (covered != ld_be)`.
- No match gives hit=0, stall=0, and the load reads memory normally.
- An entry being popped this cycle still participates in the lookup.
- When `ld_valid` = 0: hit=0, stall=0, `ld_data`=0.

Reset:
- `hp`, `tp`, `count` = 0; all valid bits cleared.
- Outputs: `st_ready`=1, `empty`=1, `count`=0, `mem_we`=0, `ld_hit`=0, `ld_stall`=0.
- Reset asserted mid-drain discards all entries; uncommitted stores are lost.

## Timing
- Store-to-memory latency is at least 1 cycle: a push at cycle t gives `mem_we` at t+1 when the buffer was empty.
- Throughput is 1 push and 1 pop per cycle.
- Forwarding is same-cycle, with zero latency from `ld_*` to `ld_hit`/`ld_data`/`ld_stall`.
- `count`, `empty` and `st_ready` update on the clock edge after a push or pop.
- `ld_stall` clears no later than the cycle after the last overlapping entry pops.
- Pointers wrap modulo DEPTH; full is distinguished from empty by `count`, not by pointer equality.

## Test plan
- Reset, then push word 0x100/0xDEADBEEF/be=F with `mem_ready`=0. Expect `count`=1 and `mem_we`=1 holding 0x100/0xDEADBEEF. Raising `mem_ready` for one cycle gives `empty`=1.
- Fill 4 stores with `mem_ready`=0. Expect `st_ready`=0 at `count`=4 and a fifth push ignored. Pop once, then push; expect order preserved across the pointer wrap.
- Push 0x200 be=F data 0x11223344, then 0x200 be=1 data 0x000000AA. Load 0x200 be=F: expect `ld_hit`=1, `ld_data`=0x112233AA, `ld_stall`=0.
- Buffer holds 0x300 be=3. Load 0x300 be=F: expect `ld_stall`=1, `ld_hit`=0. Drain the entry; the next cycle expects `ld_stall`=0, `ld_hit`=0.
- Same-cycle push of 0x400 be=F data 0x55 and load of 0x400 be=F: expect `ld_hit`=1, `ld_data`=0x55.
- Three entries held, assert reset for one cycle: expect `count`=0, `empty`=1, `mem_we`=0, `st_ready`=1, and a load to 0x100 gives `ld_hit`=0.

Source files
------------

// File: rtl/core_store_buffer_if.sv
// Bundle between the execute stage, the store buffer and the data memory port.
// The slave modport is the store buffer; the master modport is the core/memory side.
interface core_store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [BE_W-1:0]   st_be;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [BE_W-1:0]   ld_be;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_stall;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;

  logic              empty;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  st_valid, st_addr, st_data, st_be,
    output st_ready,
    input  ld_valid, ld_addr, ld_be,
    output ld_hit, ld_data, ld_stall,
    output mem_we, mem_addr, mem_data, mem_be,
    input  mem_ready,
    output empty, count
  );

  modport master (
    output st_valid, st_addr, st_data, st_be,
    input  st_ready,
    output ld_valid, ld_addr, ld_be,
    input  ld_hit, ld_data, ld_stall,
    input  mem_we, mem_addr, mem_data, mem_be,
    output mem_ready,
    input  empty, count
  );
endinterface

// File: rtl/core_store_buffer.sv
// DEPTH-entry store FIFO between EX and the data memory port, with same-cycle
// store-to-load forwarding of the youngest matching bytes and partial-overlap stall.
module core_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                reset,
  core_store_buffer_if.slave sb
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(BE_W);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];
  logic [BE_W-1:0]   be_d   [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  hp_q, hp_d;
  logic [PTR_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              st_ready_s;
  logic              mem_we_s;
  logic              push_s;
  logic              pop_s;
  logic [BE_W-1:0]   covered_s;
  logic [DATA_W-1:0] fwd_data_s;

  // Full is judged on registered occupancy only, so a same-cycle pop never frees a slot.
  assign st_ready_s = (count_q != CNT_W'(DEPTH));
  assign mem_we_s   = (count_q != {CNT_W{1'b0}});
  assign push_s     = sb.st_valid & st_ready_s;
  assign pop_s      = mem_we_s & sb.mem_ready;

  // Next-state for FIFO storage, pointers and occupancy.
  always_comb begin
    hp_d    = hp_q;
    tp_d    = tp_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (push_s) begin
      addr_d[tp_q]  = sb.st_addr;
      data_d[tp_q]  = sb.st_data;
      be_d[tp_q]    = sb.st_be;
      valid_d[tp_q] = 1'b1;
      tp_d          = tp_q + PTR_W'(1);
    end else begin
      tp_d = tp_q;
    end
    if (pop_s) begin
      valid_d[hp_q] = 1'b0;
      hp_d          = hp_q + PTR_W'(1);
    end else begin
      hp_d = hp_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every buffered store.
  always_ff @(posedge clk) begin
    if (reset) begin
      hp_q    <= {PTR_W{1'b0}};
      tp_q    <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      valid_q <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= {ADDR_W{1'b0}};
        data_q[k] <= {DATA_W{1'b0}};
        be_q[k]   <= {BE_W{1'b0}};
      end
    end else begin
      hp_q    <= hp_d;
      tp_q    <= tp_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  // Forwarding walks oldest to youngest so later matches overwrite earlier bytes;
  // the store being accepted this cycle is applied last as the youngest candidate.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = hp_q;
    covered_s  = {BE_W{1'b0}};
    fwd_data_s = {DATA_W{1'b0}};
    if (sb.ld_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = hp_q + PTR_W'(k);
        if (valid_q[idx] && (addr_q[idx][ADDR_W-1:OFF_W] == sb.ld_addr[ADDR_W-1:OFF_W])) begin
          for (int i = 0; i < BE_W; i++) begin
            if (be_q[idx][i] && sb.ld_be[i]) begin
              covered_s[i]         = 1'b1;
              fwd_data_s[8*i +: 8] = data_q[idx][8*i +: 8];
            end else begin
              covered_s[i] = covered_s[i];
            end
          end
        end else begin
          covered_s = covered_s;
        end
      end
      if (push_s && (sb.st_addr[ADDR_W-1:OFF_W] == sb.ld_addr[ADDR_W-1:OFF_W])) begin
        for (int i = 0; i < BE_W; i++) begin
          if (sb.st_be[i] && sb.ld_be[i]) begin
            covered_s[i]         = 1'b1;
            fwd_data_s[8*i +: 8] = sb.st_data[8*i +: 8];
          end else begin
            covered_s[i] = covered_s[i];
          end
        end
      end else begin
        covered_s = covered_s;
      end
    end else begin
      covered_s = {BE_W{1'b0}};
    end
  end

  assign sb.st_ready = st_ready_s;
  assign sb.mem_we   = mem_we_s;
  assign sb.mem_addr = addr_q[hp_q];
  assign sb.mem_data = data_q[hp_q];
  assign sb.mem_be   = be_q[hp_q];
  assign sb.empty    = ~mem_we_s;
  assign sb.count    = count_q;
  assign sb.ld_data  = fwd_data_s;
  assign sb.ld_hit   = sb.ld_valid & (covered_s == sb.ld_be) & (sb.ld_be != {BE_W{1'b0}});
  assign sb.ld_stall = sb.ld_valid & (covered_s != {BE_W{1'b0}}) & (covered_s != sb.ld_be);
endmodule

// File: tb/tb_core_store_buffer.sv
// Directed bench for core_store_buffer: FIFO order/full/wrap, commit handshake,
// forwarding merge, partial-overlap stall, same-cycle push forwarding, reset.
module tb_core_store_buffer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  core_store_buffer_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) sbif ();
  core_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sbif.st_valid = v;
    sbif.st_addr  = a;
    sbif.st_data  = d;
    sbif.st_be    = be;
  endtask

  task automatic set_load(input logic v, input logic [31:0] a, input logic [3:0] be);
    sbif.ld_valid = v;
    sbif.ld_addr  = a;
    sbif.ld_be    = be;
  endtask

  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];

  initial begin
    reset = 1'b1;
    sbif.mem_ready = 1'b0;
    set_store(1'b0, 32'h0, 32'h0, 4'h0);
    set_load(1'b0, 32'h0, 4'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_count", 64'(sbif.count), 64'd0);
    check("rst_empty", 64'(sbif.empty), 64'd1);
    check("rst_st_ready", 64'(sbif.st_ready), 64'd1);
    check("rst_mem_we", 64'(sbif.mem_we), 64'd0);
    check("rst_ld_hit", 64'(sbif.ld_hit), 64'd0);
    check("rst_ld_stall", 64'(sbif.ld_stall), 64'd0);

    // single store, no pass-through, then commit
    set_store(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    #1;
    check("no_passthru_we", 64'(sbif.mem_we), 64'd0);
    tick();
    set_store(1'b0, 32'h0, 32'h0, 4'h0);
    check("one_count", 64'(sbif.count), 64'd1);
    check("one_we", 64'(sbif.mem_we), 64'd1);
    check("one_addr", 64'(sbif.mem_addr), 64'h100);
    check("one_data", 64'(sbif.mem_data), 64'hDEADBEEF);
    tick();
    check("hold_addr", 64'(sbif.mem_addr), 64'h100);
    sbif.mem_ready = 1'b1;
    tick();
    sbif.mem_ready = 1'b0;
    check("drain_empty", 64'(sbif.empty), 64'd1);
    check("drain_count", 64'(sbif.count), 64'd0);

    // fill to DEPTH, reject when full (even alongside a pop), wrap order
    for (int k = 0; k < 4; k++) begin
      set_store(1'b1, 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF);
      tick();
    end
    check("full_count", 64'(sbif.count), 64'd4);
    check("full_st_ready", 64'(sbif.st_ready), 64'd0);
    set_store(1'b1, 32'h2000, 32'hBAD, 4'hF);
    tick();
    check("full_ignore_count", 64'(sbif.count), 64'd4);
    check("full_ignore_head", 64'(sbif.mem_addr), 64'h1000);
    sbif.mem_ready = 1'b1;
    tick();
    sbif.mem_ready = 1'b0;
    check("full_pop_no_push", 64'(sbif.count), 64'd3);
    set_store(1'b1, 32'h3000, 32'hE0, 4'hF);
    tick();
    set_store(1'b0, 32'h0, 32'h0, 4'h0);
    check("wrap_count", 64'(sbif.count), 64'd4);
    exp_addr[0] = 32'h1004; exp_data[0] = 32'hA1;
    exp_addr[1] = 32'h1008; exp_data[1] = 32'hA2;
    exp_addr[2] = 32'h100C; exp_data[2] = 32'hA3;
    exp_addr[3] = 32'h3000; exp_data[3] = 32'hE0;
    sbif.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("order_addr", 64'(sbif.mem_addr), 64'(exp_addr[k]));
      check("order_data", 64'(sbif.mem_data), 64'(exp_data[k]));
      tick();
    end
    sbif.mem_ready = 1'b0;
    check("order_empty", 64'(sbif.empty), 64'd1);

    // youngest-byte merge
    set_store(1'b1, 32'h200, 32'h11223344, 4'hF);
    tick();
    set_store(1'b1, 32'h200, 32'h000000AA, 4'h1);
    tick();
    set_store(1'b0, 32'h0, 32'h0, 4'h0);
    set_load(1'b1, 32'h200, 4'hF);
    #1;
    check("merge_hit", 64'(sbif.ld_hit), 64'd1);
    check("merge_data", 64'(sbif.ld_data), 64'h112233AA);
    check("merge_stall", 64'(sbif.ld_stall), 64'd0);
    set_load(1'b1, 32'h203, 4'hF);
    #1;
    check("key_offset_hit", 64'(sbif.ld_hit), 64'd1);
    set_load(1'b1, 32'h204, 4'hF);
    #1;
    check("miss_hit", 64'(sbif.ld_hit), 64'd0);
    check("miss_stall", 64'(sbif.ld_stall), 64'd0);
    check("miss_data", 64'(sbif.ld_data), 64'h0);
    set_load(1'b1, 32'h200, 4'h0);
    #1;
    check("be0_hit", 64'(sbif.ld_hit), 64'd0);
    set_load(1'b1, 32'h200, 4'h2);
    #1;
    check("lane1_data", 64'(sbif.ld_data), 64'h00003300);
    set_load(1'b0, 32'h0, 4'h0);
    sbif.mem_ready = 1'b1;
    tick();
    tick();
    sbif.mem_ready = 1'b0;
    check("merge_drained", 64'(sbif.empty), 64'd1);

    // partial overlap stall, cleared after drain
    set_store(1'b1, 32'h300, 32'h0000BEEF, 4'h3);
    tick();
    set_store(1'b0, 32'h0, 32'h0, 4'h0);
    set_load(1'b1, 32'h300, 4'hF);
    #1;
    check("part_stall", 64'(sbif.ld_stall), 64'd1);
    check("part_hit", 64'(sbif.ld_hit), 64'd0);
    sbif.mem_ready = 1'b1;
    #1;
    check("popping_stall", 64'(sbif.ld_stall), 64'd1);
    tick();
    sbif.mem_ready = 1'b0;
    #1;
    check("after_stall", 64'(sbif.ld_stall), 64'd0);
    check("after_hit", 64'(sbif.ld_hit), 64'd0);

    // same-cycle push forwarding
    set_load(1'b1, 32'h400, 4'hF);
    set_store(1'b1, 32'h400, 32'h00000055, 4'hF);
    #1;
    check("same_cyc_hit", 64'(sbif.ld_hit), 64'd1);
    check("same_cyc_data", 64'(sbif.ld_data), 64'h55);
    tick();
    set_store(1'b1, 32'h400, 32'h00006600, 4'h2);
    #1;
    check("same_cyc_young", 64'(sbif.ld_data), 64'h00006655);
    tick();
    set_store(1'b1, 32'h100, 32'h12345678, 4'hF);
    tick();
    set_store(1'b0, 32'h0, 32'h0, 4'h0);
    set_load(1'b0, 32'h0, 4'h0);
    #1;
    check("idle_ld_data", 64'(sbif.ld_data), 64'h0);
    check("pre_rst_count", 64'(sbif.count), 64'd3);

    // reset mid-occupancy discards entries
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_count", 64'(sbif.count), 64'd0);
    check("mid_rst_empty", 64'(sbif.empty), 64'd1);
    check("mid_rst_we", 64'(sbif.mem_we), 64'd0);
    check("mid_rst_ready", 64'(sbif.st_ready), 64'd1);
    set_load(1'b1, 32'h100, 4'hF);
    #1;
    check("mid_rst_ld_hit", 64'(sbif.ld_hit), 64'd0);
    set_load(1'b0, 32'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
